// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - shared PRESENT-80 widths, constants, state encoding and key rotation helper
package present_pkg;

    localparam int PRESENT_KEY_W   = 80;
    localparam int PRESENT_BLK_W   = 64;
    localparam int PRESENT_NUM_RK  = 32;
    localparam int PRESENT_KEY_ROT = 61;
    localparam int PRESENT_IDX_W   = 5;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } ks_state_e;

    // Rotate an 80-bit key left by 61 with bit 0 as the MSB (k79 = k[0]).
    function automatic logic [0:PRESENT_KEY_W-1] key_rotate(input logic [0:PRESENT_KEY_W-1] k);
        return {k[PRESENT_KEY_ROT:PRESENT_KEY_W-1], k[0:PRESENT_KEY_ROT-1]};
    endfunction

endpackage

// File: rtl/present80_key_schedule_if.sv
// rtl/present80_key_schedule_if.sv - key load / round-key stream interface of the PRESENT-80 key schedule
//
// Signals (bit 0 is the MSB on all buses):
//   abort      synchronous abandon of the current schedule
//   key_valid  master key offered;   key_ready  master key accepted
//   key_in     [0:79] master key, key_in[0] = k79
//   rk_valid   round key available;  rk_ready   consumer takes the round key
//   rk         [0:63] current round key
//   rk_idx     [4:0]  index of rk (wraps to 0 for index 32)
//   rk_last    rk is the final round key of the schedule
// master: key source / round-key consumer side.  slave: the key schedule.
interface present80_key_schedule_if;
    import present_pkg::*;

    logic                       abort;
    logic                       key_valid;
    logic                       key_ready;
    logic [0:PRESENT_KEY_W-1]   key_in;
    logic                       rk_valid;
    logic                       rk_ready;
    logic [0:PRESENT_BLK_W-1]   rk;
    logic [PRESENT_IDX_W-1:0]   rk_idx;
    logic                       rk_last;

    modport master (
        output abort,
        output key_valid,
        output key_in,
        output rk_ready,
        input  key_ready,
        input  rk_valid,
        input  rk,
        input  rk_idx,
        input  rk_last
    );

    modport slave (
        input  abort,
        input  key_valid,
        input  key_in,
        input  rk_ready,
        output key_ready,
        output rk_valid,
        output rk,
        output rk_idx,
        output rk_last
    );

endinterface

// File: rtl/present80_key_schedule_sbox.sv
// rtl/present80_key_schedule_sbox.sv - PRESENT 4-bit S-box, same table as the datapath S-box layer
//
// Ports:
//   a  in  [0:3]  input nibble, a[0] is the MSB
//   y  out [0:3]  substituted nibble, y[0] is the MSB
module present80_key_schedule_sbox (
    input  logic [0:3] a,
    output logic [0:3] y
);

    always_comb begin
        y = 4'h0;
        case (a)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            4'hF: y = 4'h2;
            default: y = 4'h0;
        endcase
    end

endmodule

// File: rtl/present80_key_schedule.sv
// rtl/present80_key_schedule.sv - PRESENT-80 round-key generator feeding the add-round-key stage
//
// Loads an 80-bit master key, then streams round keys K1..K_NUM_RK, one per accepted
// rk_valid/rk_ready handshake, applying the PRESENT-80 key update between keys.
//
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   ks     slave modport of present80_key_schedule_if (abort, key load, round-key stream)
// Parameters:
//   NUM_RK round keys emitted per load, legal range 2..32
module present80_key_schedule
    import present_pkg::*;
#(
    parameter int NUM_RK = PRESENT_NUM_RK
) (
    input  logic                     clk,
    input  logic                     rst_n,
    present80_key_schedule_if.slave  ks
);

    // rk_idx is 5 bits wide, so index 32 is carried as 0; within RUN the counter
    // starts at 1, which keeps that encoding unambiguous for the last-key decode.
    localparam logic [PRESENT_IDX_W-1:0] LAST_IDX = PRESENT_IDX_W'(NUM_RK);

    ks_state_e                  state_q, state_d;
    logic [0:PRESENT_KEY_W-1]   key_q, key_d;
    logic [PRESENT_IDX_W-1:0]   idx_q, idx_d;

    logic [0:PRESENT_KEY_W-1]   key_rot;
    logic [0:3]                 sbox_out;
    logic [0:PRESENT_KEY_W-1]   key_upd;
    logic                       at_last;

    // Key update: rotate, substitute the top nibble, fold the round counter into k19..k15.
    assign key_rot = key_rotate(key_q);

    present80_key_schedule_sbox u_sbox (
        .a (key_rot[0:3]),
        .y (sbox_out)
    );

    assign key_upd = {sbox_out, key_rot[4:59], key_rot[60:64] ^ idx_q, key_rot[65:79]};

    assign at_last = (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;

        if (ks.abort) begin
            // Abort wins over both a load and a handshake in the same cycle.
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ks.key_valid) begin
                        key_d   = ks.key_in;
                        idx_d   = PRESENT_IDX_W'(1);
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (ks.rk_ready) begin
                        if (at_last) begin
                            // Last key consumed: key register holds, schedule ends.
                            state_d = ST_IDLE;
                            idx_d   = '0;
                        end else begin
                            key_d = key_upd;
                            idx_d = idx_q + PRESENT_IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // All outputs come straight from registers, so nothing reaches rk/rk_idx from rk_ready.
    assign ks.key_ready = (state_q == ST_IDLE);
    assign ks.rk_valid  = (state_q == ST_RUN);
    assign ks.rk        = key_q[0:PRESENT_BLK_W-1];
    assign ks.rk_idx    = idx_q;
    assign ks.rk_last   = (state_q == ST_RUN) && at_last;

endmodule
